// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
// bus_drive() maps a sequencer position onto the SIOC level and the SIOD pull-down.
package sccb_pkg;

    typedef enum logic [3:0] {
        PWRUP,
        FETCH,
        START,
        BIT,
        STOP,
        GAP,
        DELAY,
        DONE,
        ERR
    } sccb_state_e;

    localparam logic [15:0] END_ENTRY   = 16'hFFFF;
    localparam logic [15:0] DELAY_ENTRY = 16'hFFF0;
    localparam int          SCCB_WORD_BITS = 27;

    // Returns {sioc, siod_oe}; siod_oe=1 pulls SIOD low, 0 releases it.
    function automatic logic [1:0] bus_drive(input sccb_state_e st,
                                             input logic [1:0]  q,
                                             input logic        data_bit);
        logic [1:0] drv;
        drv = 2'b10;
        case (st)
            START: begin
                case (q)
                    2'd0:    drv = 2'b10;
                    2'd1:    drv = 2'b11;
                    default: drv = 2'b01;
                endcase
            end
            BIT: begin
                drv = {q[1], ~data_bit};
            end
            STOP: begin
                case (q)
                    2'd0:    drv = 2'b01;
                    2'd1:    drv = 2'b11;
                    default: drv = 2'b10;
                endcase
            end
            default: drv = 2'b10;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/sccb_cam_config_timer.sv
// Free-running cycle counter that the sequencer restarts on state entry
// and at every quarter-bit boundary.
module sccb_cam_config_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         restart,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sccb_cam_config.sv
// Walks a {reg_addr, data} table and issues one 3-phase SCCB write per entry
// to the OV7670, with power-up wait, embedded delays and end/overrun detection.
module sccb_cam_config
    import sccb_pkg::*;
#(
    parameter int          QUARTER_CYC = 125,
    parameter int          PWRUP_CYC   = 50_000_000,
    parameter int          DELAY_CYC   = 500_000,
    parameter int          MAX_ENTRIES = 256,
    parameter logic [7:0]  DEV_ADDR    = 8'h42
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           start,
    output logic [$clog2(MAX_ENTRIES)-1:0] rom_addr,
    input  logic [15:0]                    rom_data,
    output logic                           sioc,
    output logic                           siod_oe,
    input  logic                           siod_in,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [7:0]                     nack_cnt
);

    localparam int AW      = $clog2(MAX_ENTRIES);
    localparam int LONGEST = (PWRUP_CYC > DELAY_CYC) ?
                             ((PWRUP_CYC > QUARTER_CYC) ? PWRUP_CYC : QUARTER_CYC) :
                             ((DELAY_CYC > QUARTER_CYC) ? DELAY_CYC : QUARTER_CYC);
    localparam int CW      = $clog2(LONGEST + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_ENTRIES - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(SCCB_WORD_BITS - 1);

    sccb_state_e                state, state_nx;
    logic [1:0]                 q, q_nx;
    logic [4:0]                 bit_idx, bit_nx;
    logic [SCCB_WORD_BITS-1:0]  shift, shift_nx;
    logic [AW-1:0]              addr_nx;
    logic [7:0]                 nack_nx;
    logic [CW-1:0]              cnt;
    logic                       qtick, bus_phase, restart;
    logic                       drv_sioc, drv_oe;

    sccb_cam_config_timer #(.W(CW)) u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .restart (restart),
        .count   (cnt)
    );

    // Next-state, table walk and ack sampling; bus levels are decoded from the
    // next position so the registered sioc/siod_oe line up with the state.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        bit_nx    = bit_idx;
        shift_nx  = shift;
        addr_nx   = rom_addr;
        nack_nx   = nack_cnt;
        qtick     = (cnt == CW'(QUARTER_CYC - 1));
        bus_phase = (state inside {START, BIT, STOP, GAP});

        if (bus_phase && qtick) begin
            q_nx = q + 2'd1;
        end

        case (state)
            PWRUP: begin
                if (cnt == CW'(PWRUP_CYC - 1)) state_nx = FETCH;
            end
            FETCH: begin
                q_nx   = 2'd0;
                bit_nx = 5'd0;
                if (rom_data == END_ENTRY) begin
                    state_nx = DONE;
                end else if (rom_data == DELAY_ENTRY) begin
                    state_nx = DELAY;
                end else begin
                    shift_nx = {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                    state_nx = START;
                end
            end
            START: begin
                if (qtick && q == 2'd3) state_nx = BIT;
            end
            BIT: begin
                if (qtick && q == 2'd3) begin
                    if ((bit_idx == 5'd8 || bit_idx == 5'd17 || bit_idx == LAST_BIT) &&
                        siod_in && nack_cnt != 8'hFF) begin
                        nack_nx = nack_cnt + 8'd1;
                    end
                    shift_nx = {shift[SCCB_WORD_BITS-2:0], 1'b0};
                    if (bit_idx == LAST_BIT) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 5'd1;
                    end
                end
            end
            STOP: begin
                if (qtick && q == 2'd3) state_nx = GAP;
            end
            GAP, DELAY: begin
                if ((state == GAP && qtick && q == 2'd3) ||
                    (state == DELAY && cnt == CW'(DELAY_CYC - 1))) begin
                    if (rom_addr == LAST_ADDR) begin
                        state_nx = ERR;
                    end else begin
                        addr_nx  = rom_addr + 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            DONE, ERR: begin
                if (start) begin
                    nack_nx  = 8'd0;
                    addr_nx  = '0;
                    state_nx = FETCH;
                end
            end
            default: state_nx = PWRUP;
        endcase

        restart = (state_nx != state) || (bus_phase && qtick);
        {drv_sioc, drv_oe} = bus_drive(state_nx, q_nx, shift_nx[SCCB_WORD_BITS-1]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= PWRUP;
            q        <= 2'd0;
            bit_idx  <= 5'd0;
            shift    <= '0;
            rom_addr <= '0;
            nack_cnt <= 8'd0;
            sioc     <= 1'b1;
            siod_oe  <= 1'b0;
        end else begin
            state    <= state_nx;
            q        <= q_nx;
            bit_idx  <= bit_nx;
            shift    <= shift_nx;
            rom_addr <= addr_nx;
            nack_cnt <= nack_nx;
            sioc     <= drv_sioc;
            siod_oe  <= drv_oe;
        end
    end

    assign busy = !(state inside {DONE, ERR});
    assign done = (state == DONE);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_sccb_cam_config.sv
// Directed bench: decodes the SCCB bus through an open-drain SIOD model and
// scores decoded bytes against a queue of expected write bytes.
module tb_sccb_cam_config;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sioc, siod_oe, busy, done, err;
    logic [7:0]  nack_cnt;
    logic        siod_line;
    logic        ack_pull = 1'b0;
    logic        ack_armed = 1'b0;

    logic [15:0] tbl [0:255];
    logic [7:0]  exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    assign rom_data  = tbl[rom_addr];
    assign siod_line = (siod_oe || ack_pull) ? 1'b0 : 1'b1;

    sccb_cam_config #(
        .QUARTER_CYC (2),
        .PWRUP_CYC   (10),
        .DELAY_CYC   (20),
        .MAX_ENTRIES (256),
        .DEV_ADDR    (8'h42)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sioc     (sioc),
        .siod_oe  (siod_oe),
        .siod_in  (siod_line),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .nack_cnt (nack_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushWrite(input logic [15:0] e);
        exp_q.push_back(8'h42);
        exp_q.push_back(e[15:8]);
        exp_q.push_back(e[7:0]);
    endtask

    task automatic applyStimulus();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    function automatic logic probe(input int k);
        case (k)
            0:       return done;
            1:       return err;
            2:       return siod_oe;
            default: return (rom_addr == 8'd1);
        endcase
    endfunction

    // n = number of negedges until the probe is seen, or -1 on timeout
    task automatic waitUntil(input int k, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge CLK);
            if (probe(k)) begin
                n = i;
                break;
            end
        end
    endtask

    // Bus monitor: start/stop detection, bit capture on SIOC rise, ack injection.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0;
    logic       m_scl, m_sda, in_frame = 1'b0;
    logic [7:0] sr = 8'h00;
    logic [7:0] exp_b;
    int         bitcnt = 0, byte_idx = 0, starts = 0, stops = 0, bus_events = 0;

    always @(negedge CLK) begin
        m_scl = sioc;
        m_sda = siod_line;
        if (!RST_N) begin
            in_frame = 1'b0;
            ack_pull = 1'b0;
        end else begin
            if (m_scl != prev_scl || siod_oe != prev_oe) bus_events++;
            if (prev_scl && m_scl && prev_sda && !m_sda) begin
                starts++;
                in_frame = 1'b1;
                bitcnt   = 0;
                byte_idx = 0;
            end else if (prev_scl && m_scl && !prev_sda && m_sda && in_frame) begin
                stops++;
                in_frame = 1'b0;
                checkOutput("frame_bytes", byte_idx, 3);
            end else if (!prev_scl && m_scl && in_frame) begin
                if (bitcnt < 8) begin
                    sr = {sr[6:0], m_sda};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        checkOutput("byte_expected", (exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            exp_b = exp_q.pop_front();
                            checkOutput("byte", sr, exp_b);
                        end
                    end
                end else begin
                    checkOutput("ack_release", siod_oe, 0);
                    bitcnt = 0;
                    byte_idx++;
                end
            end else if (prev_scl && !m_scl && in_frame) begin
                ack_pull = ack_armed && bitcnt == 8 && byte_idx == 0;
            end
        end
        prev_scl = m_scl;
        prev_sda = m_sda;
        prev_oe  = siod_oe;
    end

    initial begin
        int n, t, ev0;

        for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;

        $display("[TB] reset state");
        #12;
        checkOutput("rst_sioc", sioc, 1);
        checkOutput("rst_siod_oe", siod_oe, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_nack", nack_cnt, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);

        $display("[TB] single write 12/80 after power-up");
        tbl[0] = 16'h1280;
        tbl[1] = 16'hFFFF;
        pushWrite(16'h1280);
        @(negedge CLK);
        RST_N = 1'b1;
        waitUntil(0, 1000, n);
        checkOutput("done_latency", n, 252);
        checkOutput("w1_rom_addr", rom_addr, 1);
        checkOutput("w1_nack", nack_cnt, 3);
        checkOutput("w1_busy", busy, 0);
        checkOutput("w1_sioc_idle", sioc, 1);
        checkOutput("w1_siod_idle", siod_oe, 0);
        checkOutput("w1_starts", starts, 1);
        checkOutput("w1_stops", stops, 1);
        checkOutput("w1_queue_left", exp_q.size(), 0);

        $display("[TB] delay entry, start ignored while busy");
        tbl[0] = 16'hFFF0;
        tbl[1] = 16'h1101;
        tbl[2] = 16'hFFFF;
        pushWrite(16'h1101);
        applyStimulus();
        t = 1;
        checkOutput("restart_nack_clear", nack_cnt, 0);
        checkOutput("restart_busy", busy, 1);
        ev0 = bus_events;
        repeat (3) @(negedge CLK);
        t += 3;
        applyStimulus();
        t += 2;
        waitUntil(3, 200, n);
        checkOutput("delay_len", (n < 0) ? -1 : t + n, 22);
        checkOutput("delay_quiet", bus_events, ev0);
        t += n;
        waitUntil(0, 1000, n);
        checkOutput("delay_done_latency", (n < 0) ? -1 : t + n, 264);
        checkOutput("d_nack", nack_cnt, 3);
        checkOutput("d_queue_left", exp_q.size(), 0);

        $display("[TB] restart from DONE with ack on first byte");
        tbl[0] = 16'h1280;
        tbl[1] = 16'hFFFF;
        pushWrite(16'h1280);
        ack_armed = 1'b1;
        applyStimulus();
        waitUntil(2, 100, n);
        checkOutput("start_cond_latency", (n < 0) ? -1 : n + 1, 4);
        waitUntil(0, 1000, n);
        checkOutput("ack_done", done, 1);
        checkOutput("ack_nack", nack_cnt, 2);
        ack_armed = 1'b0;

        $display("[TB] reset during second write");
        tbl[0] = 16'h1280;
        tbl[1] = 16'h1101;
        tbl[2] = 16'hFFFF;
        pushWrite(16'h1280);
        pushWrite(16'h1101);
        applyStimulus();
        waitUntil(3, 1000, n);
        repeat (20) @(negedge CLK);
        for (int i = 0; i < 20 && sioc != 1'b0; i++) @(negedge CLK);
        #1 RST_N = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checkOutput("midrst_sioc", sioc, 1);
        checkOutput("midrst_siod_oe", siod_oe, 0);
        checkOutput("midrst_rom_addr", rom_addr, 0);
        checkOutput("midrst_busy", busy, 1);
        checkOutput("midrst_nack", nack_cnt, 0);
        pushWrite(16'h1280);
        pushWrite(16'h1101);
        @(negedge CLK);
        RST_N = 1'b1;
        waitUntil(0, 2000, n);
        checkOutput("two_write_latency", n, 493);
        checkOutput("two_write_nack", nack_cnt, 6);
        checkOutput("two_write_queue_left", exp_q.size(), 0);

        $display("[TB] table overrun without sentinel");
        for (int i = 0; i < 256; i++) begin
            tbl[i] = 16'h0101;
            pushWrite(16'h0101);
        end
        applyStimulus();
        waitUntil(1, 70000, n);
        checkOutput("overrun_latency", (n < 0) ? -1 : n + 1, 61697);
        checkOutput("ovr_err", err, 1);
        checkOutput("ovr_done", done, 0);
        checkOutput("ovr_busy", busy, 0);
        checkOutput("ovr_sioc", sioc, 1);
        checkOutput("ovr_siod_oe", siod_oe, 0);
        checkOutput("ovr_rom_addr", rom_addr, 255);
        checkOutput("ovr_nack_sat", nack_cnt, 255);
        checkOutput("ovr_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sccb_cam_config.md
Name: sccb_cam_config

Overview:
- Sequences the OV7670 camera's power-up register programming over the SCCB bus (sioc/siod on ARDUINO_IO[15:14]).
- Walks an external register table of {reg_addr, data} entries and issues one 3-phase SCCB write per entry.
- Handles start/stop framing, open-drain SIOD, inter-write gaps and table-embedded delays (e.g. after soft reset 0x12/0x80).
- Raises done so the pixel path (camera_read, frame RAM) can be held off until the sensor is configured.

Parameters:
- QUARTER_CYC, 125: CLK cycles per quarter SCCB bit (50 MHz gives 100 kHz SIOC).
- PWRUP_CYC, 50_000_000: cycles waited after reset release before the first write (1 s).
- DELAY_CYC, 500_000: cycles waited for a delay entry (10 ms).
- MAX_ENTRIES, 256: table depth limit; width of rom_addr is clog2(MAX_ENTRIES).
- DEV_ADDR, 8'h42: SCCB write ID byte.

Ports:
- CLK, in, 1: system clock (MAX10_CLK1_50).
- RST_N, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse; re-runs the table from entry 0. Honoured only in DONE or ERR.
- rom_addr, out, 8: current table index.
- rom_data, in, 16: {reg_addr[15:8], data[7:0]}; combinational, valid in the same cycle.
- sioc, out, 1: SCCB clock, push-pull.
- siod_oe, out, 1: 1 = pull SIOD low; 0 = release (pulled high externally).
- siod_in, in, 1: sampled SIOD line.
- busy, out, 1: high in any state other than DONE or ERR.
- done, out, 1: table completed with the end sentinel.
- err, out, 1: table overran MAX_ENTRIES without a sentinel.
- nack_cnt, out, 8: count of 9th-bit samples reading high; saturates at 255; informational only, writes are never retried.

Behaviour:
- Reset values: sioc=1, siod_oe=0, busy=1, done=0, err=0, nack_cnt=0, rom_addr=0, state=PWRUP.
- A quarter tick fires every QUARTER_CYC cycles from a free counter that restarts on every state entry. Every bus transition occurs on a tick.
- Entry decode on rom_data:
  - 16'hFFFF: end of table.
  - 16'hFFF0: delay entry.
  - anything else: write entry.
- PWRUP: count PWRUP_CYC, then go to FETCH.
- FETCH (1 cycle):
  - End sentinel: go to DONE.
  - Delay entry: go to DELAY.
  - Write entry: latch a 27-bit shift word {DEV_ADDR,1'b1, reg_addr,1'b1, data,1'b1}, then go to START. The 1s in the 9th positions release SIOD for the don't-care/ack bit.
  - Entry reached with rom_addr==MAX_ENTRIES-1 that is not the end sentinel: go to ERR after processing it.
- START (4 quarters): Q0 sioc=1, siod_oe=0; Q1 siod_oe=1 (SDA falls while SCL high); Q2 sioc=0; Q3 hold. Go to BIT.
- BIT (27 bits × 4 quarters, MSB first):
  - Q0: sioc=0, siod_oe=~bit.
  - Q1: hold.
  - Q2: sioc=1.
  - Q3: hold. On the Q3 tick of bits 8/17/26, if siod_in==1 then nack_cnt++ (saturating).
- STOP (4 quarters): Q0 sioc=0, siod_oe=1; Q1 sioc=1; Q2 siod_oe=0 (SDA rises while SCL high); Q3 hold.
- GAP: 4 quarters idle with the bus released, then rom_addr++ and go to FETCH.
- DELAY: count DELAY_CYC with the bus released, then rom_addr++ and go to FETCH.
- DONE: done=1, busy=0, bus released (sioc=1, siod_oe=0).
- ERR: err=1, busy=0, bus released.
- start pulse in DONE or ERR: clear done, err and nack_cnt; rom_addr=0; go directly to FETCH with no power-up wait.
- start while busy: ignored.
- RST_N low mid-transfer: all state returns to reset values on the same edge. sioc/siod return high immediately. No stop condition is generated; the sensor resynchronises on the next start.
- Write timing: one write = (4+108+4+4) quarters = 120 × QUARTER_CYC cycles, plus 1 FETCH cycle.

Decomposition:
- Package sccb_pkg:
  - State enum (PWRUP, FETCH, START, BIT, STOP, GAP, DELAY, DONE, ERR).
  - Sentinel constants END_ENTRY=16'hFFFF and DELAY_ENTRY=16'hFFF0.
  - SCCB_WORD_BITS=27.
- Sub-module ov7670_reg_rom: combinational case ROM holding the RGB565/VGA table, instantiated beside this block in final_proj. This block stays table-agnostic.
- Top-level wiring:
  - ARDUINO_IO[14] = siod_oe ? 1'b0 : 1'bz.
  - siod_in = ARDUINO_IO[14].
  - ARDUINO_IO[15] = sioc.

Test Plan (QUARTER_CYC=2, PWRUP_CYC=10, DELAY_CYC=20, bench open-drain SIOD model with pull-up):
- Reset then table {16'h1280, 16'hFFFF}: one start, bits 0x42,X,0x12,X,0x80,X decoded on sioc rising edges, then stop. done=1 at cycle 10+1+240+1 after reset; rom_addr=1.
- Table {16'hFFF0, 16'h1101, 16'hFFFF}: no bus activity for 20 cycles after the first FETCH, then the write of 0x11/0x01, then done.
- Bench acks (pulls SIOD low) only on the 1st 9th-bit: nack_cnt=2 after one write; the write still completes and done=1.
- Table with 256 normal entries and no sentinel: err=1, done=0, busy=0 after the 256th stop+gap, bus released.
- RST_N asserted during BIT of the second write: next cycle sioc=1, siod_oe=0, rom_addr=0, busy=1. After release, the first write restarts after PWRUP.
- start pulse while busy: ignored. start in DONE: no power-up wait, first start condition within 1+1 quarter, nack_cnt cleared.
